djb2_hash_stream: RTL and testbench

Parametrised streaming djb2 hash engine: the next generation of the lab's single-word hash IP. It accepts a message as a sequence of valid/ready beats, each carrying 1..CHARS characters of CHAR_W bits. It folds one character per cycle into the running hash, selectable as djb2 (add) or djb2a (xor), and presents the final digest on a valid/ready output port. It sits behind the AXI-Lite register wrapper, in place of the command-word interface.

---
 rtl/djb2_pkg.sv | 15 +
 rtl/djb2_step.sv | 24 ++
 rtl/djb2_hash_stream.sv | 127 ++++++++++++
 tb/tb_djb2_hash_stream.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/djb2_pkg.sv
// Shared constants and state encoding for the streaming djb2/djb2a hash engine.
package djb2_pkg;

    localparam int unsigned DJB2_HASH_INIT = 5381;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_XOR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/djb2_step.sv
// One djb2 round: h*33 then add (djb2) or xor (djb2a) the zero-extended character.
module djb2_step
    import djb2_pkg::*;
#(
    parameter int HASH_W = 32,
    parameter int CHAR_W = 8
) (
    input  logic [HASH_W-1:0] h,
    input  logic [CHAR_W-1:0] c,
    input  logic              mode,
    output logic [HASH_W-1:0] h_next
);

    logic [HASH_W-1:0] c_ext;
    logic [HASH_W-1:0] h33;

    always_comb begin
        c_ext              = '0;
        c_ext[CHAR_W-1:0]  = c;
        h33                = (h << 5) + h;
        h_next             = (mode == MODE_XOR) ? (h33 ^ c_ext) : (h33 + c_ext);
    end

endmodule

// File: rtl/djb2_hash_stream.sv
// Streaming djb2/djb2a hash: accepts multi-character beats, folds one character per
// cycle into the running hash and offers the digest on a valid/ready output.
module djb2_hash_stream
    import djb2_pkg::*;
#(
    parameter int          CHAR_W    = 8,
    parameter int          CHARS     = 4,
    parameter int          HASH_W    = 32,
    parameter int unsigned HASH_INIT = DJB2_HASH_INIT,
    parameter int          CNT_W     = (CHARS > 1) ? $clog2(CHARS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    mode_xor,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHARS*CHAR_W-1:0] in_data,
    input  logic [CNT_W-1:0]        in_count,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HASH_W-1:0]       out_hash,
    output logic                    busy
);

    localparam logic [HASH_W-1:0] INIT_H  = HASH_W'(HASH_INIT);
    localparam logic [CNT_W-1:0]  MAX_IDX = CNT_W'(CHARS - 1);

    state_t                    state;
    state_t                    state_next;
    logic [HASH_W-1:0]         hash_q;
    logic [HASH_W-1:0]         hash_step;
    logic [CHARS*CHAR_W-1:0]   data_q;
    logic [CNT_W-1:0]          count_q;
    logic                      last_q;
    logic [CNT_W-1:0]          idx_q;
    logic                      mode_q;
    logic                      msg_open;
    logic [CHAR_W-1:0]         cur_char;

    // Handshakes: a beat transfers on a rising edge where in_valid && in_ready, the
    // digest on one where out_valid && out_ready; producers hold valid and payload
    // stable until the transfer, and ready never depends combinationally on valid.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_hash  = hash_q;

    assign cur_char = data_q[idx_q*CHAR_W +: CHAR_W];

    djb2_step #(
        .HASH_W (HASH_W),
        .CHAR_W (CHAR_W)
    ) u_step (
        .h      (hash_q),
        .c      (cur_char),
        .mode   (mode_q),
        .h_next (hash_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (in_valid)           state_next = ST_CALC;
            ST_CALC: if (idx_q == count_q)   state_next = last_q ? ST_DONE : ST_IDLE;
            ST_DONE: if (out_ready)          state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_q   <= INIT_H;
            data_q   <= '0;
            count_q  <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            mode_q   <= MODE_ADD;
            msg_open <= 1'b0;
        end else if (clear) begin
            hash_q   <= INIT_H;
            msg_open <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        count_q <= (in_count > MAX_IDX) ? MAX_IDX : in_count;
                        last_q  <= in_last;
                        idx_q   <= '0;
                        // Mode is latched only on the first beat of a message.
                        if (!msg_open) begin
                            mode_q   <= mode_xor;
                            msg_open <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    hash_q <= hash_step;
                    if (idx_q != count_q) begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        hash_q   <= INIT_H;
                        msg_open <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_djb2_hash_stream.sv
// Self-checking bench for djb2_hash_stream: directed cases pinned to literal digests
// plus randomized multi-beat messages scored against a plain-arithmetic hash model.
module tb_djb2_hash_stream;

    typedef logic [7:0] char_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;

    logic        mode_xor, in_valid, in_ready, in_last, out_valid, out_ready, busy;
    logic [31:0] in_data;
    logic [1:0]  in_count;
    logic [31:0] out_hash;

    logic        mode3, in_valid3, in_ready3, in_last3, out_valid3, out_ready3, busy3;
    logic [23:0] in_data3;
    logic [1:0]  in_count3;
    logic [31:0] out_hash3;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] exp_q[$];
    char_q_t     msg_chars;
    bit          msg_mode;
    bit          msg_open_m;

    djb2_hash_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode_xor  (mode_xor),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .busy      (busy)
    );

    djb2_hash_stream #(.CHARS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode_xor  (mode3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_count  (in_count3),
        .in_last   (in_last3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_hash  (out_hash3),
        .busy      (busy3)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference: djb2 over the whole message with 32-bit wrap.
    function automatic logic [31:0] model_hash(input char_q_t chars, input bit mx);
        logic [31:0] h;
        h = 32'd5381;
        foreach (chars[i]) begin
            if (mx) h = (h * 32'd33) ^ {24'd0, chars[i]};
            else    h = (h * 32'd33) + {24'd0, chars[i]};
        end
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        msg_chars.delete();
        msg_open_m = 1'b0;
    endtask

    // Driver: present one beat and hold it until accepted.
    task automatic send_beat(input logic [31:0] data, input int cnt, input bit last, input bit mx);
        bit acc;
        bit accepted;
        accepted = 1'b0;
        in_data  = data;
        in_count = cnt[1:0];
        in_last  = last;
        mode_xor = mx;
        in_valid = 1'b1;
        for (int w = 0; w < 200 && !accepted; w++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) accepted = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!accepted) begin
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            if (!msg_open_m) begin
                msg_mode   = mx;
                msg_open_m = 1'b1;
            end
            for (int k = 0; k <= cnt; k++) msg_chars.push_back(data[k*8 +: 8]);
            if (last) begin
                exp_q.push_back(model_hash(msg_chars, msg_mode));
                msg_chars.delete();
                msg_open_m = 1'b0;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int w;
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check(name, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume(input bit rnd);
        bit hs;
        bit got;
        got = 1'b0;
        for (int w = 0; w < 500 && !got; w++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            if (hs) got = 1'b1;
        end
        out_ready = 1'b0;
        check("consume_done", {31'd0, got}, 32'd1);
    endtask

    task automatic run_msg(input int nbeats, input bit mx, input bit rnd_ready);
        logic [31:0] d;
        int          c;
        bit          m;
        for (int b = 0; b < nbeats; b++) begin
            d = $urandom();
            c = $urandom_range(0, 3);
            m = (b == 0) ? mx : 1'($urandom_range(0, 1));
            send_beat(d, c, b == nbeats - 1, m);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        consume(rnd_ready);
    endtask

    // Scoreboard: every cycle the digest is offered it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL cmp_unexpected_digest actual=%0d required=none", out_hash);
            end else begin
                if (out_hash !== exp_q[0]) begin
                    failures++;
                    $display("FAIL cmp_digest actual=%0d required=%0d", out_hash, exp_q[0]);
                end
                if (out_ready && !clear) void'(exp_q.pop_front());
            end
        end
    end

    initial begin : main
        char_q_t     q;
        logic [31:0] h0;
        int          lat;

        rst_n = 1'b0; clear = 1'b0;
        mode_xor = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; in_last = 1'b0;
        out_ready = 1'b0;
        mode3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; in_count3 = '0; in_last3 = 1'b0;
        out_ready3 = 1'b0;
        msg_mode = 1'b0; msg_open_m = 1'b0;

        // Pin the model to hand-computed digests.
        q = '{8'h61};               check("model_a_add", model_hash(q, 1'b0), 32'd177670);
        q = '{8'h61};               check("model_a_xor", model_hash(q, 1'b1), 32'd177604);
        q = '{8'h61, 8'h62};        check("model_ab",    model_hash(q, 1'b0), 32'd5863208);
        q = '{8'h61, 8'h62, 8'h63}; check("model_abc",   model_hash(q, 1'b0), 32'd193485963);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_hash",  out_hash,           32'd5381);
        check("rst_busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "a", add mode, with digest timing
        send_beat(32'h61, 0, 1'b1, 1'b0);
        check("a_latency_calc", {31'd0, out_valid}, 32'd0);
        check("a_busy",         {31'd0, busy},      32'd1);
        @(posedge clk); #1;
        check("a_latency_done", {31'd0, out_valid}, 32'd1);
        check("a_hash",         out_hash,           32'd177670);
        consume(1'b0);

        // "a", xor mode
        send_beat(32'h61, 0, 1'b1, 1'b1);
        wait_valid("a_xor_valid");
        check("a_xor_hash", out_hash, 32'd177604);
        consume(1'b0);

        // "ab" held back by out_ready
        send_beat(32'h6261, 1, 1'b1, 1'b0);
        wait_valid("ab_valid");
        h0 = out_hash;
        check("ab_hash", h0, 32'd5863208);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_valid",    {31'd0, out_valid}, 32'd1);
            check("hold_hash",     out_hash,           h0);
            check("hold_in_ready", {31'd0, in_ready},  32'd0);
            check("hold_busy",     {31'd0, busy},      32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        check("release_hash",     out_hash,          32'd5381);

        // Split message "a","b"
        send_beat(32'h61, 0, 1'b0, 1'b0);
        send_beat(32'h62, 0, 1'b1, 1'b1);
        wait_valid("split_valid");
        check("split_hash", out_hash, 32'd5863208);
        consume(1'b0);

        // "abc"
        send_beat(32'h636261, 2, 1'b1, 1'b0);
        wait_valid("abc_valid");
        check("abc_hash", out_hash, 32'd193485963);
        consume(1'b0);

        // clear mid-CALC of a 4-char beat
        send_beat(32'h64636261, 3, 1'b1, 1'b0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        flush_model();
        check("clr_hash",     out_hash,           32'd5381);
        check("clr_valid",    {31'd0, out_valid}, 32'd0);
        check("clr_in_ready", {31'd0, in_ready},  32'd1);
        check("clr_busy",     {31'd0, busy},      32'd0);
        send_beat(32'h61, 0, 1'b1, 1'b0);
        wait_valid("clr_a_valid");
        check("clr_a_hash", out_hash, 32'd177670);
        consume(1'b0);

        // asynchronous reset mid-CALC
        send_beat(32'h64636261, 3, 1'b1, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_hash",     out_hash,           32'd5381);
        check("arst_valid",    {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready},  32'd1);
        check("arst_busy",     {31'd0, busy},      32'd0);
        flush_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(32'h61, 0, 1'b1, 1'b0);
        wait_valid("arst_a_valid");
        check("arst_a_hash", out_hash, 32'd177670);
        consume(1'b0);

        // in_count beyond CHARS-1 on the 3-char instance saturates to 3 chars
        in_data3 = 24'h636261; in_count3 = 2'd3; in_last3 = 1'b1; mode3 = 1'b0;
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q = '{8'h61, 8'h62, 8'h63};
        check("sat_latency", lat, 32'd3);
        check("sat_hash",    out_hash3, model_hash(q, 1'b0));
        check("sat_literal", out_hash3, 32'd193485963);
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        check("sat_release", out_hash3, 32'd5381);

        // Long random messages in both modes, then a batch of short ones
        run_msg(40, 1'b0, 1'b1);
        run_msg(40, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            run_msg($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
